pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits; must be a multiple of STAGES.
REQ-002 SHALL have parameter STAGES, default 4: number of pipeline stages; chunk width CW = WIDTH/STAGES.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: an operand set is presented.
REQ-006 SHALL have port in_ready, output, 1: the block accepts an operand set this cycle.
REQ-007 SHALL have port a, input, WIDTH: signed operand A.
REQ-008 SHALL have port b, input, WIDTH: signed operand B.
REQ-009 SHALL have port cin, input, 1: carry-in; used only when sub=0.
REQ-010 SHALL have port sub, input, 1: 0 selects a+b+cin; 1 selects a-b.
REQ-011 SHALL have port out_valid, output, 1: a result is presented.
REQ-012 SHALL have port out_ready, input, 1: the consumer accepts the result.
REQ-013 SHALL have port sum, output, WIDTH: signed result.
REQ-014 SHALL have port cout, output, 1: carry out of the MSB.
REQ-015 SHALL have port overflow, output, 1: signed two's-complement overflow.

Function
REQ-016 SHALL accept an operand set on a cycle where in_valid && in_ready is true.
REQ-017 SHALL compute, for sub=1, a + ~b + 1, ignoring cin.
REQ-018 SHALL have stage k (0..STAGES-1) add chunk k, bits [k*CW +: CW], plus the carry registered by stage k-1; stage 0 uses the effective carry-in.
REQ-019 SHALL delay the upper, not-yet-added operand chunks and the lower, completed sum chunks alongside the carry, in skew registers.
REQ-020 SHALL present a result with out_valid high exactly STAGES cycles after acceptance, provided no stall occurs.
REQ-021 SHALL take cout as the carry out of bit WIDTH-1.
REQ-022 SHALL set overflow = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), where b_eff is b, or ~b when sub=1.
REQ-023 SHALL drive in_ready = !out_valid || out_ready.
REQ-024 SHALL hold every pipeline register, including valid bits, when in_ready is low (global stall).
REQ-025 SHALL keep sum, cout and overflow stable while out_valid && !out_ready.
REQ-026 SHALL let bubbles advance when in_valid=0; a stage's valid bit clears when nothing enters it.
REQ-027 SHALL sustain throughput of one result per cycle while out_ready=1.
REQ-028 SHALL deliver results in acceptance order; no result is dropped or duplicated.

Reset
REQ-029 SHALL, on a clock edge with rst=1, clear all stage valid bits, giving out_valid=0, sum=0, cout=0 and overflow=0 from the next cycle.
REQ-030 SHALL discard all in-flight operations when rst is asserted mid-operation; none of them emerges after reset.
REQ-031 SHALL drive in_ready=1 during and immediately after reset.

Configuration
REQ-032 SHALL support the macro ADDER_SATURATE_EN; when it is defined and overflow=1, sum SHALL clamp to the signed maximum (a non-negative) or the signed minimum (a negative).
REQ-033 SHALL present the wrapped sum when ADDER_SATURATE_EN is undefined; overflow and cout behave identically in both builds.

Structure
REQ-034 SHALL place the default WIDTH/STAGES constants and the result struct type {sum, cout, overflow} in the shared package adder_pkg.
REQ-035 SHALL instantiate sub-module adder_stage once per stage; adder_stage is a CW-bit ripple add of chunk plus carry-in, with a registered sum chunk and carry-out and a stall enable.

Verification
REQ-036 SHALL cover, with WIDTH=32 and STAGES=4: a=2147483647, b=1, sub=0 -> 4 cycles later sum=-2147483648, overflow=1, cout=0; with ADDER_SATURATE_EN, sum=2147483647.
REQ-037 SHALL cover: a=-2147483648, b=1, sub=1 -> sum=2147483647, overflow=1 (saturated build: -2147483648).
REQ-038 SHALL cover: a=32'h00FFFFFF, b=1, cin=0 -> sum=32'h01000000, carry rippling across three chunk boundaries, overflow=0.
REQ-039 SHALL cover: 8 back-to-back inputs (100-50, 200+150, -100+-200, ...) with out_ready low for 3 cycles mid-stream -> outputs 50, 350, -300, ... in order, in_ready low during the stall, no loss.
REQ-040 SHALL cover: rst pulsed for 1 cycle with 3 operations in flight -> out_valid=0 next cycle, and no stale result appears within the following STAGES cycles.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and result bundle for the pipelined adder.
// Optional build macro: ADDER_SATURATE_EN (see pipelined_adder.sv).
package adder_pkg;

    localparam int ADDER_WIDTH  = 32;
    localparam int ADDER_STAGES = 4;

    typedef struct packed {
        logic [ADDER_WIDTH-1:0] sum;
        logic                   cout;
        logic                   overflow;
    } adder_result_t;

endpackage

// File: rtl/adder_stage.sv
// One pipeline slice: CW-bit ripple add of a chunk plus carry-in,
// with registered sum chunk, carry-out and valid, all held while en is low.
module adder_stage
    import adder_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          in_valid,
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic          valid_q,
    output logic [CW-1:0] sum_q,
    output logic          cout_q
);

    logic          valid_d;
    logic [CW-1:0] sum_d;
    logic          cout_d;
    logic [CW:0]   c;

    always_comb begin
        c       = '0;
        c[0]    = cin;
        sum_d   = '0;
        for (int i = 0; i < CW; i++) begin
            sum_d[i] = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout_d  = c[CW];
        valid_d = in_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (en) begin
            valid_q <= valid_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// Carry-pipelined signed adder/subtractor with valid/ready flow control.
// Define ADDER_SATURATE_EN to clamp overflowing sums to the signed limits.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = ADDER_WIDTH,
    parameter int STAGES = ADDER_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = WIDTH / STAGES;
    localparam int M  = WIDTH - 1;

    logic                          en;
    logic [WIDTH-1:0]              b_eff;
    logic [STAGES-1:0]             st_vin, st_cin, st_vq, st_cq;
    logic [STAGES-1:0][CW-1:0]     st_a, st_b, st_s;
    logic [STAGES-1:0][WIDTH-1:0]  a_q, a_d, b_q, b_d, ps_q, ps_d;
    logic [WIDTH-1:0]              fin_sum, wrap_sum;
    logic                          fin_ovf;

    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign out_valid = st_vq[STAGES-1];

    // Row k skews the not-yet-added operand chunks and the finished low sum chunks
    always_comb begin
        b_eff     = sub ? ~b : b;
        a_d[0]    = a;
        b_d[0]    = b_eff;
        ps_d[0]   = '0;
        st_vin[0] = in_valid;
        st_cin[0] = sub | cin;
        st_a[0]   = a[CW-1:0];
        st_b[0]   = b_eff[CW-1:0];
        for (int k = 1; k < STAGES; k++) begin
            a_d[k]                  = a_q[k-1];
            b_d[k]                  = b_q[k-1];
            ps_d[k]                 = ps_q[k-1];
            ps_d[k][(k-1)*CW +: CW] = st_s[k-1];
            st_vin[k]               = st_vq[k-1];
            st_cin[k]               = st_cq[k-1];
            st_a[k]                 = a_q[k-1][k*CW +: CW];
            st_b[k]                 = b_q[k-1][k*CW +: CW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            ps_q <= '0;
        end else if (en) begin
            a_q  <= a_d;
            b_q  <= b_d;
            ps_q <= ps_d;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_stage #(.CW(CW)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .in_valid (st_vin[k]),
            .a        (st_a[k]),
            .b        (st_b[k]),
            .cin      (st_cin[k]),
            .valid_q  (st_vq[k]),
            .sum_q    (st_s[k]),
            .cout_q   (st_cq[k])
        );
    end

    always_comb begin
        wrap_sum = ps_q[STAGES-1];
        wrap_sum[(STAGES-1)*CW +: CW] = st_s[STAGES-1];
        fin_ovf = (a_q[STAGES-1][M] == b_q[STAGES-1][M])
               && (wrap_sum[M] != a_q[STAGES-1][M]);
        fin_sum = wrap_sum;
`ifdef ADDER_SATURATE_EN
        if (fin_ovf) begin
            fin_sum    = {WIDTH{~a_q[STAGES-1][M]}};
            fin_sum[M] = a_q[STAGES-1][M];
        end
`endif
    end

    if (WIDTH == ADDER_WIDTH) begin : g_res_pkg
        adder_result_t res;
        assign res      = {fin_sum, st_cq[STAGES-1], fin_ovf};
        assign sum      = res.sum;
        assign cout     = res.cout;
        assign overflow = res.overflow;
    end else begin : g_res_raw
        assign sum      = fin_sum;
        assign cout     = st_cq[STAGES-1];
        assign overflow = fin_ovf;
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (WIDTH=32, STAGES=4).
// Expected sums follow the ADDER_SATURATE_EN build setting.
module tb_pipelined_adder;

    localparam int W = 32;
    localparam int S = 4;
`ifdef ADDER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, cin, sub;
    logic         out_valid, out_ready, cout, overflow;
    logic [W-1:0] a, b, sum;
    int           passed = 0;
    int           total  = 0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL rst_in_ready_during: got %b want 1", in_ready);
        else passed++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid);
        else passed++;
        total++;
        if (sum !== 32'h0) $display("FAIL rst_sum: got %h want 0", sum);
        else passed++;
        total++;
        if ({cout, overflow} !== 2'b00) $display("FAIL rst_flags: got %b want 00", {cout, overflow});
        else passed++;
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL rst_in_ready_after: got %b want 1", in_ready);
        else passed++;
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tcin, input logic tsub,
                          input logic [W-1:0] es, input logic ec, input logic eo,
                          input string nm);
        int lat;
        a = ta; b = tb_v; cin = tcin; sub = tsub;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (lat + 1 != S) $display("FAIL %s_latency: got %0d cycles want %0d", nm, lat + 1, S);
        else passed++;
        total++;
        if (sum !== es) $display("FAIL %s_sum: got %h want %h", nm, sum, es);
        else passed++;
        total++;
        if (cout !== ec) $display("FAIL %s_cout: got %b want %b", nm, cout, ec);
        else passed++;
        total++;
        if (overflow !== eo) $display("FAIL %s_overflow: got %b want %b", nm, overflow, eo);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_overflow_add();
        run_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0,
               SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1, "ovf_add");
    endtask

    task automatic test_overflow_sub();
        run_op(32'h8000_0000, 32'h1, 1'b0, 1'b1,
               SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1, "ovf_sub");
    endtask

    task automatic test_carry_ripple();
        run_op(32'h00FF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, "ripple");
    endtask

    task automatic test_cin_cout();
        run_op(32'd5, 32'd3, 1'b1, 1'b0, 32'd9, 1'b0, 1'b0, "cin_add");
        run_op(32'd10, 32'd3, 1'b1, 1'b1, 32'd7, 1'b1, 1'b0, "sub_ign_cin");
        run_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, "wrap_cout");
    endtask

    task automatic test_back_to_back();
        int va[8] = '{100, 200, -100, 7, 0, 1000, -5, 123};
        int vb[8] = '{50, 150, -200, 8, 1, 1000, 5, 456};
        bit vs[8] = '{1, 0, 0, 0, 1, 1, 0, 0};
        int ve[8] = '{50, 350, -300, 15, -1, 0, 0, 579};
        int sent = 0;
        int rcv  = 0;
        int cyc  = 0;
        int seen = 0;
        cin = 1'b0;
        while (rcv < 8 && cyc < 60) begin
            out_ready = !(cyc >= 6 && cyc <= 8);
            if (sent < 8) begin
                a = va[sent]; b = vb[sent]; sub = vs[sent]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (!out_ready) begin
                total++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1)
                    $display("FAIL b2b_stall_ready: in_ready %b out_valid %b want 0 1",
                             in_ready, out_valid);
                else passed++;
                total++;
                if (sum !== ve[rcv])
                    $display("FAIL b2b_stall_hold: got %0d want %0d", $signed(sum), ve[rcv]);
                else passed++;
            end
            if (out_valid === 1'b1 && out_ready) begin
                total++;
                if (sum !== ve[rcv])
                    $display("FAIL b2b_result_%0d: got %0d want %0d", rcv, $signed(sum), ve[rcv]);
                else passed++;
                rcv++;
            end
            if (in_valid && in_ready === 1'b1) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++;
        if (rcv != 8) $display("FAIL b2b_count: got %0d results want 8", rcv);
        else passed++;
        for (int i = 0; i < S + 1; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0) $display("FAIL b2b_no_extra: got %0d extra results want 0", seen);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midflight();
        int seen = 0;
        out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 32'(i + 1) * 32'd11; b = 32'd4; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) $display("FAIL mid_rst_in_ready: got %b want 1", in_ready);
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0 || sum !== 32'h0)
            $display("FAIL mid_rst_clear: out_valid %b sum %h want 0 0", out_valid, sum);
        else passed++;
        for (int i = 0; i < S; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0) $display("FAIL mid_rst_stale: got %0d results want 0", seen);
        else passed++;
        @(posedge clk); #1;
        run_op(32'd40, 32'd2, 1'b0, 1'b0, 32'd42, 1'b0, 1'b0, "post_rst");
    endtask

    initial begin
        test_reset();
        test_overflow_add();
        test_overflow_sub();
        test_carry_ripple();
        test_cin_cout();
        test_back_to_back();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
